muldiv_sequencer: RTL and testbench

- Multi-cycle controller/datapath for RV32M multiply/divide, sequenced beside the main ALU in the execute stage.
- Accepts one operation through a valid/ready handshake and iterates one bit per cycle (shift-add multiply, restoring divide).
- Holds the result until the consumer takes it, and drives a busy/stall flag to the hazard unit while an operation is in flight.

---
 rtl/muldiv_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: shift-add multiply and restoring divide, one bit per cycle.
// Optional MULDIV_FLUSH_EN adds i_flush, which kills any operation in flight.
module muldiv_sequencer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_result,
    output logic              o_busy,
    output logic              o_div_by_zero
`ifdef MULDIV_FLUSH_EN
    ,
    input  logic              i_flush
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state, state_next;

    logic                flush;
    logic [2:0]          op;
    logic [DATA_W-1:0]   a, b;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   opnd;
    logic                neg;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   result;
    logic                dbz;

`ifdef MULDIV_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    // Operand decode on the latched request
    logic              is_div, is_rem, signed_a, signed_b, a_neg, b_neg;
    logic [DATA_W-1:0] a_abs, b_abs;
    logic              b_zero, ovf, special;
    logic [DATA_W-1:0] special_res;

    always_comb begin
        is_div   = op[2];
        is_rem   = op[2] & op[1];
        signed_a = is_div ? ~op[0] : (op == 3'b001 || op == 3'b010);
        signed_b = is_div ? ~op[0] : (op == 3'b001);
        a_neg    = signed_a & a[DATA_W-1];
        b_neg    = signed_b & b[DATA_W-1];
        a_abs    = a_neg ? -a : a;
        b_abs    = b_neg ? -b : b;
        b_zero   = (b == '0);
        ovf      = is_div && !op[0] && (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == '1);
        special  = is_div && (b_zero || ovf);
        if (b_zero)
            special_res = is_rem ? a : '1;
        else
            special_res = is_rem ? '0 : a;
    end

    // One iteration step. Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide: acc = {partial remainder, remaining dividend bits / quotient bits}.
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     trial;
    logic                fits;
    logic [DATA_W-1:0]   diff;
    logic [2*DATA_W-1:0] div_next;
    logic [2*DATA_W-1:0] calc_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opnd};
        mul_next  = acc[0] ? {mul_sum, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W-1:1]};
        trial     = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
        fits      = (trial >= {1'b0, opnd});
        diff      = trial[DATA_W-1:0] - opnd;
        div_next  = {(fits ? diff : trial[DATA_W-1:0]), acc[DATA_W-2:0], fits};
        calc_next = is_div ? div_next : mul_next;
    end

    // Sign fix-up and field select
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   quo, rmd, fix_res;

    always_comb begin
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        rmd  = neg ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
        case (op)
            3'b000:                 fix_res = prod[DATA_W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[2*DATA_W-1:DATA_W];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rmd;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_busy     = 1'b1;
        o_valid    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid)
                    state_next = PREP;
            end
            PREP:    state_next = special ? DONE : CALC;
            CALC:    state_next = (cnt == '0) ? FIX : CALC;
            FIX:     state_next = DONE;
            DONE: begin
                o_valid = 1'b1;
                if (i_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op     <= '0;
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            result <= '0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && !flush) begin
                        op <= i_op;
                        a  <= i_op_a;
                        b  <= i_op_b;
                    end
                end
                PREP: begin
                    cnt  <= CNT_W'(DATA_W - 1);
                    neg  <= is_rem ? a_neg : (a_neg ^ b_neg);
                    opnd <= is_div ? b_abs : a_abs;
                    acc  <= {{DATA_W{1'b0}}, (is_div ? a_abs : b_abs)};
                    dbz  <= special && b_zero;
                    if (special)
                        result <= special_res;
                end
                CALC: begin
                    acc <= calc_next;
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                end
                FIX:     result <= fix_res;
                default: ;
            endcase
        end
    end

    assign o_result      = result;
    assign o_div_by_zero = dbz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed table, random ops vs. arithmetic model,
// backpressure, reset and (with MULDIV_FLUSH_EN) flush sequences.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  op;
    logic [31:0] op_a, op_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        busy;
    logic        dbz;
`ifdef MULDIV_FLUSH_EN
    logic        flush;
`endif

    int checks   = 0;
    int failures = 0;

    muldiv_sequencer #(.DATA_W(32)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (req_valid),
        .o_ready       (req_ready),
        .i_op          (op),
        .i_op_a        (op_a),
        .i_op_b        (op_b),
        .o_valid       (res_valid),
        .i_ready       (res_ready),
        .o_result      (result),
        .o_busy        (busy),
        .o_div_by_zero (dbz)
`ifdef MULDIV_FLUSH_EN
        ,
        .i_flush       (flush)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain 64-bit arithmetic plus the RV32M special-case rules.
    function automatic void model(input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output int lat);
        longint          sa, sb, p, q;
        longint unsigned ua, ub, pu;
        logic            ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        z   = 1'b0;
        lat = 35;
        r   = '0;
        case (mop)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin pu = ua * ub; r = pu[63:32]; end
            3'd4: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; z = 1'b1; lat = 2; end
                else if (ovf) begin r = 32'h8000_0000; lat = 2; end
                else begin q = sa / sb; r = q[31:0]; end
            end
            3'd5: begin
                if (b == 0) begin r = 32'hFFFF_FFFF; z = 1'b1; lat = 2; end
                else begin pu = ua / ub; r = pu[31:0]; end
            end
            3'd6: begin
                if (b == 0) begin r = a; z = 1'b1; lat = 2; end
                else if (ovf) begin r = 32'h0; lat = 2; end
                else begin q = sa % sb; r = q[31:0]; end
            end
            default: begin
                if (b == 0) begin r = a; z = 1'b1; lat = 2; end
                else begin pu = ua % ub; r = pu[31:0]; end
            end
        endcase
    endfunction

    // Called at a negedge; drives an accept and returns at the negedge of cycle c1.
    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_before_accept"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        op        = o;
        op_a      = a;
        op_b      = b;
        @(negedge clk);
        req_valid = 1'b0;
        op        = $urandom;
        op_a      = $urandom;
        op_b      = $urandom;
    endtask

    // Starting at c1, wait for o_valid and check latency and busy.
    task automatic wait_result(input string name, input int exp_lat);
        int lat     = 1;
        bit busy_ok = 1'b1;
        while (!res_valid && lat < 100) begin
            if (!busy || req_ready) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!busy || req_ready) busy_ok = 1'b0;
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy"}, {31'h0, busy_ok}, 32'h1);
    endtask

    task automatic release_result(input string name);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({name, "_cleared"}, {30'h0, res_valid, req_ready}, 32'h1);
    endtask

    task automatic do_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_dbz, input int exp_lat);
        issue(name, o, a, b);
        wait_result(name, exp_lat);
        check({name, "_result"}, result, exp_res);
        check({name, "_dbz"}, {31'h0, dbz}, {31'h0, exp_dbz});
        release_result(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[14];
        logic [31:0] exp_r, held;
        logic        exp_z;
        int          exp_l, seen;

        vecs[0]  = '{"mul_7x6",      3'd0, 32'd7,         32'd6,         32'h0000_002A, 1'b0, 35};
        vecs[1]  = '{"mulh_m1x2",    3'd1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 35};
        vecs[2]  = '{"mulhu_m1x2",   3'd3, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 1'b0, 35};
        vecs[3]  = '{"mulhsu_min",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 35};
        vecs[4]  = '{"div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 35};
        vecs[5]  = '{"rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 35};
        vecs[6]  = '{"divu_100_7",   3'd5, 32'd100,       32'd7,         32'd14,        1'b0, 35};
        vecs[7]  = '{"remu_100_7",   3'd7, 32'd100,       32'd7,         32'd2,         1'b0, 35};
        vecs[8]  = '{"divu_by0",     3'd5, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1'b1, 2};
        vecs[9]  = '{"remu_by0",     3'd7, 32'h1234_5678, 32'd0,         32'h1234_5678, 1'b1, 2};
        vecs[10] = '{"div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2};
        vecs[11] = '{"rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2};
        vecs[12] = '{"div_by0",      3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1'b1, 2};
        vecs[13] = '{"divu_big",     3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 35};

        rst       = 1'b1;
        req_valid = 1'b0;
        res_ready = 1'b0;
        op        = '0;
        op_a      = '0;
        op_b      = '0;
`ifdef MULDIV_FLUSH_EN
        flush     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_valid",  {31'h0, res_valid}, 32'h0);
        check("reset_busy",   {31'h0, busy},      32'h0);
        check("reset_ready",  {31'h0, req_ready}, 32'h1);
        check("reset_result", result,             32'h0);
        check("reset_dbz",    {31'h0, dbz},       32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dbz, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, exp_r, exp_z, exp_l);
            do_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, exp_r, exp_z, exp_l);
        end

        // Backpressure: result held for 10 cycles while a new request is offered and ignored
        issue("bp", 3'd0, 32'h0000_1234, 32'h0000_0010);
        wait_result("bp", 35);
        held = result;
        check("bp_result", held, 32'h0001_2340);
        for (int i = 0; i < 10; i++) begin
            req_valid = 1'b1;
            op        = 3'd5;
            op_a      = 32'd9;
            op_b      = 32'd0;
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), {result[31:2], res_valid, req_ready}, {held[31:2], 2'b10});
            check($sformatf("bp_hold_lsb%0d", i), {30'h0, result[1:0]}, {30'h0, held[1:0]});
        end
        req_valid = 1'b0;
        release_result("bp");
        check("bp_no_accept", {31'h0, busy}, 32'h0);
        do_op("bp_next", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 35);

        // Reset in the middle of a divide
        issue("rst_mid", 3'd4, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_valid",  {31'h0, res_valid}, 32'h0);
        check("rst_mid_busy",   {31'h0, busy},      32'h0);
        check("rst_mid_ready",  {31'h0, req_ready}, 32'h1);
        check("rst_mid_result", result,             32'h0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("rst_mid_no_valid", seen, 0);
        do_op("after_rst", 3'd4, 32'd1000, 32'd3, 32'd333, 1'b0, 35);

`ifdef MULDIV_FLUSH_EN
        issue("flush_mid", 3'd4, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_mid_state", {30'h0, res_valid, busy}, 32'h0);
        check("flush_mid_ready", {31'h0, req_ready}, 32'h1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("flush_mid_no_valid", seen, 0);

        flush     = 1'b1;
        req_valid = 1'b1;
        op        = 3'd0;
        op_a      = 32'd3;
        op_b      = 32'd3;
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        check("flush_idle_discard", {31'h0, busy}, 32'h0);

        issue("flush_done", 3'd5, 32'd5, 32'd0);
        wait_result("flush_done", 2);
        flush     = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        res_ready = 1'b0;
        check("flush_done_state", {30'h0, res_valid, busy}, 32'h0);
        do_op("after_flush", 3'd0, 32'd9, 32'd9, 32'd81, 1'b0, 35);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
